// File: rtl/aurora_20g_adc_packer.sv
// Packs two headers and eight ADC words into a 9-beat AXIS frame for the Aurora TX.
// Beats 0..4 interleave half-words through a hold register; beats 5..8 pass ADC words through.
module aurora_20g_adc_packer #(
  parameter int unsigned DATA_WD = 128,
  parameter int unsigned HEAD_WD = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_rst,
  input  logic                 head_vld,
  input  logic [HEAD_WD-1:0]   head_data,
  output logic                 head_rdy,
  input  logic                 adc_vld,
  input  logic [DATA_WD-1:0]   adc_data,
  output logic                 adc_rdy,
  output logic [DATA_WD-1:0]   m_axis_tdata,
  output logic [DATA_WD/8-1:0] m_axis_tkeep,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [31:0]          frame_cnt
);

  localparam int unsigned HALF_WD = DATA_WD / 2;
  localparam int unsigned KEEP_WD = DATA_WD / 8;
  localparam int unsigned CNT_WD  = 32;

  if (HEAD_WD != HALF_WD) begin : g_bad_head_wd
    $error("aurora_20g_adc_packer: HEAD_WD must equal DATA_WD/2");
  end

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [HALF_WD-1:0]   hold_q;
  logic [HALF_WD-1:0]   hold_d;
  logic                 flush;
  logic                 out_free;
  logic                 load;
  logic [DATA_WD-1:0]   beat;
  logic                 beat_last;
  logic [HALF_WD-1:0]   adc_lo;
  logic [HALF_WD-1:0]   adc_hi;

  assign flush    = rst | cfg_rst;
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign adc_lo   = adc_data[HALF_WD-1:0];
  assign adc_hi   = adc_data[DATA_WD-1:HALF_WD];

  // Per-beat handshake, beat assembly and next-state selection.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    load      = 1'b0;
    beat      = '0;
    beat_last = 1'b0;
    head_rdy  = 1'b0;
    adc_rdy   = 1'b0;
    if (!flush) begin
      case (state_q)
        S0: begin
          head_rdy = out_free && adc_vld;
          adc_rdy  = out_free && head_vld;
          load     = out_free && head_vld && adc_vld;
          beat     = {adc_lo, head_data};
          if (load) hold_d = adc_hi;
        end
        S1, S2, S3: begin
          adc_rdy = out_free;
          load    = out_free && adc_vld;
          beat    = {adc_lo, hold_q};
          if (load) hold_d = adc_hi;
        end
        S4: begin
          head_rdy = out_free;
          load     = out_free && head_vld;
          beat     = {head_data, hold_q};
        end
        S5, S6, S7: begin
          adc_rdy = out_free;
          load    = out_free && adc_vld;
          beat    = adc_data;
        end
        S8: begin
          adc_rdy   = out_free;
          load      = out_free && adc_vld;
          beat      = adc_data;
          beat_last = 1'b1;
        end
        default: state_d = S0;
      endcase
      if (load) state_d = (state_q == S8) ? S0 : state_t'(state_q + 4'd1);
    end
  end

  // State and hold register; a flush restarts packing at beat 0.
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= S0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Single output register stage plus frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      frame_cnt     <= '0;
    end else if (cfg_rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
    end else begin
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= beat;
        m_axis_tlast  <= beat_last;
        m_axis_tkeep  <= {KEEP_WD{1'b1}};
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        frame_cnt <= frame_cnt + CNT_WD'(1);
      end
    end
  end

endmodule

// File: tb/tb_aurora_20g_adc_packer.sv
// Bench for aurora_20g_adc_packer: randomized sources/sink against a frame-layout model
// built from the words actually consumed.
module tb_aurora_20g_adc_packer;

  localparam int unsigned DW = 128;
  localparam int unsigned HW = 64;
  localparam int unsigned KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_rst;
  logic          head_vld;
  logic [HW-1:0] head_data;
  logic          head_rdy;
  logic          adc_vld;
  logic [DW-1:0] adc_data;
  logic          adc_rdy;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [31:0]   frame_cnt;

  always #5 clk = ~clk;

  aurora_20g_adc_packer #(.DATA_WD(DW), .HEAD_WD(HW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_rst      (cfg_rst),
    .head_vld     (head_vld),
    .head_data    (head_data),
    .head_rdy     (head_rdy),
    .adc_vld      (adc_vld),
    .adc_data     (adc_data),
    .adc_rdy      (adc_rdy),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .frame_cnt    (frame_cnt)
  );

  logic [HW-1:0] hsrc[$];
  logic [DW-1:0] asrc[$];
  logic [HW-1:0] hq_m[$];
  logic [DW-1:0] aq_m[$];
  int            b_idx = 0;
  int unsigned   fcnt = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            beats = 0;
  bit            vh, va, vr;
  bit            p_stall = 1'b0;
  bit            p_rst = 1'b0;
  bit            p_cfg = 1'b0;
  logic [DW-1:0] p_data;
  logic          p_last;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Expected beat b of the current frame from the headers/words consumed so far.
  function automatic logic [DW-1:0] exp_beat(input int b);
    logic [DW-1:0] a_cur;
    logic [DW-1:0] a_prv;
    logic [HW-1:0] h;
    int ai = (b <= 3) ? b : b - 1;
    if (aq_m.size() <= ai) return {DW{1'bx}};
    a_cur = aq_m[ai];
    case (b)
      0: begin
        if (hq_m.size() < 1) return {DW{1'bx}};
        h = hq_m[0];
        return {a_cur[HW-1:0], h};
      end
      1, 2, 3: begin
        a_prv = aq_m[b-1];
        return {a_cur[HW-1:0], a_prv[DW-1:HW]};
      end
      4: begin
        if (hq_m.size() < 2) return {DW{1'bx}};
        h = hq_m[1];
        return {h, a_cur[DW-1:HW]};
      end
      default: return a_cur;
    endcase
  endfunction

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 2; j++) hsrc.push_back({$urandom, $urandom});
      for (int k = 0; k < 8; k++) asrc.push_back({$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  task automatic push_nominal();
    logic [7:0] bt;
    hsrc.push_back({16{4'h1}});
    hsrc.push_back({16{4'h2}});
    for (int k = 0; k < 8; k++) begin
      bt = 8'hA0 + 8'(k);
      asrc.push_back({16{bt}});
    end
  endtask

  // One clock: drive inputs, check at the falling edge, update the model.
  task automatic step();
    head_vld      = vh && (hsrc.size() > 0);
    head_data     = (hsrc.size() > 0) ? hsrc[0] : '0;
    adc_vld       = va && (asrc.size() > 0);
    adc_data      = (asrc.size() > 0) ? asrc[0] : '0;
    m_axis_tready = vr;
    @(negedge clk);
    chk("frame_cnt", DW'(frame_cnt), DW'(fcnt));
    if (p_rst) begin
      chk("rst_tvalid", DW'(m_axis_tvalid), '0);
      chk("rst_tlast", DW'(m_axis_tlast), '0);
      chk("rst_tdata", m_axis_tdata, '0);
      chk("rst_tkeep", DW'(m_axis_tkeep), '0);
    end else if (p_cfg) begin
      chk("flush_tvalid", DW'(m_axis_tvalid), '0);
    end else if (p_stall) begin
      chk("stall_tvalid", DW'(m_axis_tvalid), DW'(1));
      chk("stall_tdata", m_axis_tdata, p_data);
      chk("stall_tlast", DW'(m_axis_tlast), DW'(p_last));
    end
    if (rst || cfg_rst || (m_axis_tvalid && !m_axis_tready))
      chk("rdy_blocked", DW'({head_rdy, adc_rdy}), '0);
    if (m_axis_tvalid && m_axis_tready && !rst && !cfg_rst) begin
      beats++;
      chk("tdata", m_axis_tdata, exp_beat(b_idx));
      chk("tlast", DW'(m_axis_tlast), DW'(b_idx == 8));
      chk("tkeep", DW'(m_axis_tkeep), DW'({KW{1'b1}}));
      b_idx++;
      if (b_idx == 9) begin
        b_idx = 0;
        fcnt++;
        for (int j = 0; j < 2; j++) if (hq_m.size() > 0) void'(hq_m.pop_front());
        for (int k = 0; k < 8; k++) if (aq_m.size() > 0) void'(aq_m.pop_front());
      end
    end
    if (head_vld && head_rdy) begin
      hq_m.push_back(head_data);
      void'(hsrc.pop_front());
    end
    if (adc_vld && adc_rdy) begin
      aq_m.push_back(adc_data);
      void'(asrc.pop_front());
    end
    p_stall = m_axis_tvalid && !m_axis_tready;
    p_data  = m_axis_tdata;
    p_last  = m_axis_tlast;
    p_rst   = rst;
    p_cfg   = cfg_rst;
    if (rst || cfg_rst) begin
      hq_m.delete();
      aq_m.delete();
      b_idx = 0;
      if (rst) fcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sa;
    int sh;
    rst = 1'b1; cfg_rst = 1'b0;
    head_vld = 1'b0; head_data = '0; adc_vld = 1'b0; adc_data = '0; m_axis_tready = 1'b0;
    vh = 1'b0; va = 1'b0; vr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    step();

    // Nominal frame with fixed patterns.
    push_nominal();
    vh = 1'b1; va = 1'b1; vr = 1'b1; beats = 0;
    repeat (10) step();
    chk("nom_beats", DW'(beats), DW'(9));
    chk("nom_frames", DW'(frame_cnt), DW'(1));

    // Back-to-back frames: 27 beats in 27 consecutive cycles after one cycle of latency.
    push_rand(3);
    beats = 0;
    repeat (28) step();
    chk("b2b_beats", DW'(beats), DW'(27));
    chk("b2b_frames", DW'(frame_cnt), DW'(4));

    // Backpressure with tready pattern 1,0,0,1.
    push_rand(3);
    for (int i = 0; i < 120; i++) begin
      vr = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    vr = 1'b1;
    repeat (2) step();
    chk("bp_frames", DW'(frame_cnt), DW'(7));
    chk("bp_hsrc_empty", DW'(hsrc.size()), '0);
    chk("bp_asrc_empty", DW'(asrc.size()), '0);

    // Source stalls: adc_vld low 3 cycles in beat 2, head_vld low 3 cycles in beat 4.
    push_nominal();
    sa = 0; sh = 0;
    for (int i = 0; i < 40; i++) begin
      va = !(aq_m.size() == 2 && sa < 3);
      if (!va) sa++;
      vh = !(aq_m.size() == 4 && hq_m.size() == 1 && sh < 3);
      if (!vh) sh++;
      step();
    end
    vh = 1'b1; va = 1'b1;
    chk("stall_frames", DW'(frame_cnt), DW'(8));
    chk("stall_bidx", DW'(b_idx), '0);

    // Flush with beat 5 stalled at the output.
    push_rand(1);
    for (int i = 0; i < 20 && b_idx < 5; i++) step();
    chk("flush_pos", DW'(b_idx), DW'(5));
    vh = 1'b0; va = 1'b0; vr = 1'b0;
    step();
    cfg_rst = 1'b1;
    step();
    cfg_rst = 1'b0;
    hsrc.delete(); asrc.delete();
    step();
    chk("flush_frames_held", DW'(frame_cnt), DW'(8));
    push_rand(1);
    vh = 1'b1; va = 1'b1; vr = 1'b1;
    repeat (12) step();
    chk("post_flush_frames", DW'(frame_cnt), DW'(9));

    // Reset in beat 3.
    push_rand(1);
    for (int i = 0; i < 20 && aq_m.size() < 3; i++) step();
    chk("rst_pos", DW'(aq_m.size()), DW'(3));
    vh = 1'b0; va = 1'b0; vr = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    hsrc.delete(); asrc.delete();
    step();
    push_rand(1);
    vh = 1'b1; va = 1'b1; vr = 1'b1;
    repeat (12) step();
    chk("post_rst_frames", DW'(frame_cnt), DW'(1));

    // Random valid/ready traffic.
    push_rand(20);
    for (int i = 0; i < 900; i++) begin
      vh = ($urandom_range(0, 3) != 0);
      va = ($urandom_range(0, 3) != 0);
      vr = ($urandom_range(0, 2) != 0);
      step();
    end
    vh = 1'b1; va = 1'b1; vr = 1'b1;
    repeat (20) step();
    chk("rand_hsrc_empty", DW'(hsrc.size()), '0);
    chk("rand_asrc_empty", DW'(asrc.size()), '0);
    chk("rand_bidx", DW'(b_idx), '0);
    chk("rand_frames", DW'(frame_cnt), DW'(21));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aurora_20g_adc_packer.md
AURORA_20G_ADC_PACKER -- requirements
Module: aurora_20g_adc_packer

Interface
REQ-001 The block SHALL have parameter DATA_WD, default 128: AXIS beat and ADC word width in bits.
REQ-002 The block SHALL have parameter HEAD_WD, default 64: header width; legal only when HEAD_WD = DATA_WD/2.
REQ-003 Port clk, input, 1: the single clock; all logic rises on it.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port cfg_rst, input, 1: synchronous active-high frame flush, same effect as rst.
REQ-006 Ports head_vld (in, 1), head_data (in, HEAD_WD), head_rdy (out, 1): header input; a header transfers when head_vld and head_rdy are both 1.
REQ-007 Ports adc_vld (in, 1), adc_data (in, DATA_WD), adc_rdy (out, 1): ADC word input; a word transfers when adc_vld and adc_rdy are both 1.
REQ-008 Ports m_axis_tdata (out, DATA_WD), m_axis_tkeep (out, DATA_WD/8), m_axis_tvalid (out, 1), m_axis_tlast (out, 1), m_axis_tready (in, 1): AXIS output toward the Aurora TX.
REQ-009 Port frame_cnt, out, 32: count of frames completed on the output.

Function
REQ-010 Each frame SHALL be 9 beats carrying 2 headers (H0, H1) and 8 ADC words (A0..A7); L(x) = x[DATA_WD/2-1:0], U(x) = x[DATA_WD-1:DATA_WD/2].
REQ-011 Beat layout SHALL be: B0 = {L(A0), H0}; B1 = {L(A1), U(A0)}; B2 = {L(A2), U(A1)}; B3 = {L(A3), U(A2)}; B4 = {H1, U(A3)}; B5..B8 = A4..A7 unmodified.
REQ-012 States SHALL be S0..S8, one per beat, reset to S0; each state advances by one (S8 wraps to S0) only when its beat is loaded; otherwise it holds.
REQ-013 out_free SHALL be (!m_axis_tvalid || m_axis_tready).
REQ-014 In S0 the block SHALL load B0 only when out_free && head_vld && adc_vld, consuming H0 and A0 in the same cycle; head_rdy = out_free && adc_vld; adc_rdy = out_free && head_vld.
REQ-015 In S1..S3 and S5..S8 the block SHALL assert adc_rdy = out_free and head_rdy = 0, and load the beat when adc_vld && adc_rdy.
REQ-016 In S4 the block SHALL assert head_rdy = out_free and adc_rdy = 0, and load B4 when head_vld && head_rdy.
REQ-017 A 64-bit hold register SHALL capture U(Ak) when Ak is consumed in S0..S3, and supply it to the next beat's low half.
REQ-018 Output SHALL be a single register stage: a loaded beat appears on m_axis_* on the next clock, one cycle latency from input handshake.
REQ-019 m_axis_tvalid SHALL be set on load, cleared on (m_axis_tvalid && m_axis_tready) with no simultaneous load, and held otherwise.
REQ-020 m_axis_tdata/tlast SHALL stay stable while m_axis_tvalid && !m_axis_tready.
REQ-021 m_axis_tlast SHALL be 1 only on B8; m_axis_tkeep SHALL be all ones whenever m_axis_tvalid = 1.
REQ-022 With all inputs valid and m_axis_tready held at 1, the block SHALL output one beat per clock with no bubbles, including across the S8->S0 wrap.
REQ-023 frame_cnt SHALL increment by 1, wrapping 0xFFFF_FFFF->0, on each cycle with m_axis_tvalid && m_axis_tready && m_axis_tlast.
REQ-024 head_rdy and adc_rdy SHALL NOT depend combinationally on their own valid input.

Reset
REQ-025 On rst = 1 at a clock edge: state = S0, hold = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tkeep = 0, frame_cnt = 0.
REQ-026 While rst or cfg_rst is 1, head_rdy and adc_rdy SHALL be 0.
REQ-027 cfg_rst SHALL have the same effect as rst except frame_cnt is held; a partial frame is discarded, including any unaccepted output beat, and packing restarts at S0.
REQ-028 rst SHALL take priority over cfg_rst and over any simultaneous handshake.

Verification
REQ-029 Nominal: H0 = 0x1111..., A0..A3 = 0xA0..0xA3 patterns, H1 = 0x2222..., A4..A7 = 0xA4..0xA7, tready = 1 -> 9 consecutive beats matching REQ-011, tlast on beat 9 only, frame_cnt = 1.
REQ-030 Back-to-back: 3 frames, all sources always valid, tready = 1 -> 27 beats in 27 consecutive cycles, frame_cnt = 3.
REQ-031 Backpressure: tready toggles 1,0,0,1 repeating -> no beat lost or duplicated, tdata stable while stalled, rdy outputs = 0 while the output is full and unaccepted.
REQ-032 Source stalls: adc_vld low 3 cycles in S2, head_vld low in S4 -> state holds, no output bubble corruption, final stream identical to REQ-029.
REQ-033 Flush: cfg_rst pulsed in S6 with a stalled beat -> m_axis_tvalid = 0 next cycle, state S0, frame_cnt unchanged; the next frame is emitted correctly from B0.
REQ-034 Reset mid-frame: rst in S3 -> all outputs at REQ-025 values next cycle; a subsequent frame packs correctly.
